// File: rtl/hart_mem_arbiter.sv
// -----------------------------------------------------------------------------
// hart_mem_arbiter
//
// Purpose:
//   Single-port arbiter between one HART's instruction-fetch port and its
//   data-memory port, in front of a shared external memory bus. Grants one
//   request at a time, holds the granted request's fields registered on the
//   bus until i_BUS_ready, then returns the captured read data to the owner
//   with a one-cycle ready pulse. Every transaction walks IDLE -> BUSY -> RESP.
//
// Configuration:
//   ARVI_ARB_RR_EN  defined   : round-robin between fetch and data when both
//                               request in the same IDLE cycle.
//                   undefined : fixed priority, data wins.
//   PC_RESET        macro giving the default o_BUS_addr value after reset.
//
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_IC_DataReq, i_IM_Addr         fetch request / address
//   o_IM_Instr, o_IC_MemReady       fetch response word / one-cycle pulse
//   i_DM_MemRead, i_DM_Wen          load / store request (store wins if both)
//   i_DM_Addr, i_DM_Wd, i_DM_f3     data address, store data, funct3
//   o_DM_ReadData, o_DM_data_ready  data response word / one-cycle pulse
//   o_BUS_req, o_BUS_addr, o_BUS_wdata, o_BUS_wen, o_BUS_f3   bus request
//   i_BUS_rdata, i_BUS_ready        bus response, honoured only in BUSY
// -----------------------------------------------------------------------------
`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif

module hart_mem_arbiter #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = `PC_RESET
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_IC_DataReq,
  input  logic [XLEN-1:0] i_IM_Addr,
  output logic [XLEN-1:0] o_IM_Instr,
  output logic            o_IC_MemReady,
  input  logic            i_DM_MemRead,
  input  logic            i_DM_Wen,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [2:0]      i_DM_f3,
  output logic [XLEN-1:0] o_DM_ReadData,
  output logic            o_DM_data_ready,
  output logic            o_BUS_req,
  output logic [XLEN-1:0] o_BUS_addr,
  output logic [XLEN-1:0] o_BUS_wdata,
  output logic            o_BUS_wen,
  output logic [2:0]      o_BUS_f3,
  input  logic [XLEN-1:0] i_BUS_rdata,
  input  logic            i_BUS_ready
);

`ifdef ARVI_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic            owner_q;       // 0 = fetch, 1 = data
  logic            last_grant_q;  // 0 = fetch, 1 = data
  logic            bus_req_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            wen_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rdata_q;
  logic            ic_rdy_q;
  logic            dm_rdy_q;

  logic            data_req;
  logic            any_req;
  logic            grant_data_d;
  logic [XLEN-1:0] addr_d;
  logic [XLEN-1:0] wdata_d;
  logic            wen_d;
  logic [2:0]      f3_d;

  // Winner selection and the bus fields it would load. With round-robin
  // disabled the last_grant term is masked off, so data always wins a tie.
  always_comb begin
    data_req     = i_DM_MemRead | i_DM_Wen;
    any_req      = data_req | i_IC_DataReq;
    grant_data_d = data_req & (~i_IC_DataReq | ~last_grant_q | ~RR_EN);
    addr_d       = i_IM_Addr;
    wdata_d      = '0;
    wen_d        = 1'b0;
    f3_d         = F3_WORD;
    if (grant_data_d) begin
      addr_d  = i_DM_Addr;
      wdata_d = i_DM_Wd;
      wen_d   = i_DM_Wen;
      f3_d    = i_DM_f3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      bus_req_q    <= 1'b0;
      addr_q       <= PC_RESET;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      f3_q         <= 3'b000;
      rdata_q      <= '0;
      ic_rdy_q     <= 1'b0;
      dm_rdy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ic_rdy_q <= 1'b0;
          dm_rdy_q <= 1'b0;
          if (any_req) begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wen_q        <= wen_d;
            f3_q         <= f3_d;
            owner_q      <= grant_data_d;
            last_grant_q <= grant_data_d;
            bus_req_q    <= 1'b1;
            state_q      <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Bus fields stay frozen here; only the bus completion matters.
          if (i_BUS_ready) begin
            rdata_q   <= i_BUS_rdata;
            bus_req_q <= 1'b0;
            ic_rdy_q  <= ~owner_q;
            dm_rdy_q  <= owner_q;
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          // Never grant here: gives the requester one cycle to drop its request.
          ic_rdy_q <= 1'b0;
          dm_rdy_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          bus_req_q <= 1'b0;
          ic_rdy_q  <= 1'b0;
          dm_rdy_q  <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign o_BUS_req       = bus_req_q;
  assign o_BUS_addr      = addr_q;
  assign o_BUS_wdata     = wdata_q;
  assign o_BUS_wen       = wen_q;
  assign o_BUS_f3        = f3_q;
  assign o_IM_Instr      = rdata_q;
  assign o_DM_ReadData   = rdata_q;
  assign o_IC_MemReady   = ic_rdy_q;
  assign o_DM_data_ready = dm_rdy_q;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hart_mem_arbiter
//
// Self-checking bench for hart_mem_arbiter. A transaction-level reference
// (one open bus transaction, one pending response) predicts every output each
// cycle; directed scenarios add hand-computed literal expectations, then a
// randomized phase drives both requesters, a bus with random wait states and
// spurious ready pulses, and occasional resets.
// -----------------------------------------------------------------------------
module tb_hart_mem_arbiter;
  localparam logic [31:0] PCR = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        ic_rdy;
  logic        dm_rd;
  logic        dm_wen;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [2:0]  dm_f3;
  logic [31:0] dm_rdata;
  logic        dm_rdy;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wen;
  logic [2:0]  bus_f3;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  int n_checks = 0;
  int n_err    = 0;

  hart_mem_arbiter #(.XLEN(32), .PC_RESET(PCR)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_IC_DataReq    (ic_req),
    .i_IM_Addr       (im_addr),
    .o_IM_Instr      (im_instr),
    .o_IC_MemReady   (ic_rdy),
    .i_DM_MemRead    (dm_rd),
    .i_DM_Wen        (dm_wen),
    .i_DM_Addr       (dm_addr),
    .i_DM_Wd         (dm_wd),
    .i_DM_f3         (dm_f3),
    .o_DM_ReadData   (dm_rdata),
    .o_DM_data_ready (dm_rdy),
    .o_BUS_req       (bus_req),
    .o_BUS_addr      (bus_addr),
    .o_BUS_wdata     (bus_wdata),
    .o_BUS_wen       (bus_wen),
    .o_BUS_f3        (bus_f3),
    .i_BUS_rdata     (bus_rdata),
    .i_BUS_ready     (bus_ready)
  );

  always #5 clk = ~clk;

  // Reference state: the currently open bus transaction (if any), whether a
  // response is being returned this cycle, and who it belongs to.
  logic        m_open;
  logic        m_resp;
  logic        m_owner_data;
  logic        m_last_data;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_wen;
  logic [2:0]  m_f3;
  logic [31:0] m_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic was_resp, want_d, want_i, pick_d;
    if (rst) begin
      m_open = 0; m_resp = 0; m_owner_data = 0; m_last_data = 1;
      m_addr = PCR; m_wdata = 0; m_wen = 0; m_f3 = 0; m_rdata = 0;
    end else begin
      was_resp = m_resp;
      m_resp   = 0;
      want_d   = dm_rd | dm_wen;
      want_i   = ic_req;
      if (m_open) begin
        if (bus_ready) begin
          m_rdata = bus_rdata;
          m_open  = 0;
          m_resp  = 1;
        end
      end else if (!was_resp && (want_d || want_i)) begin
        pick_d = want_d;
`ifdef ARVI_ARB_RR_EN
        if (want_d && want_i) pick_d = !m_last_data;
`endif
        m_owner_data = pick_d;
        m_last_data  = pick_d;
        m_open       = 1;
        if (pick_d) begin
          m_addr = dm_addr; m_wdata = dm_wd; m_wen = dm_wen; m_f3 = dm_f3;
        end else begin
          m_addr = im_addr; m_wdata = 0; m_wen = 0; m_f3 = 3'b010;
        end
      end
    end
  endtask

  task automatic compare();
    chk("bus_req",   32'(bus_req),   32'(m_open));
    chk("bus_addr",  bus_addr,       m_addr);
    chk("bus_wdata", bus_wdata,      m_wdata);
    chk("bus_wen",   32'(bus_wen),   32'(m_wen));
    chk("bus_f3",    32'(bus_f3),    32'(m_f3));
    chk("ic_ready",  32'(ic_rdy),    32'(m_resp & ~m_owner_data));
    chk("dm_ready",  32'(dm_rdy),    32'(m_resp & m_owner_data));
    chk("im_instr",  im_instr,       m_rdata);
    chk("dm_rdata",  dm_rdata,       m_rdata);
  endtask

  // One clock: reference advances with the DUT's edge, outputs checked mid-cycle.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // From an IDLE cycle with requests set: grant, immediate bus ready, stop in RESP.
  task automatic do_txn(output logic [31:0] gaddr, input logic [31:0] rdata);
    cyc();
    gaddr     = bus_addr;
    bus_ready = 1; bus_rdata = rdata;
    cyc();
    bus_ready = 0;
  endtask

  logic [31:0] g;

  initial begin
    rst = 1; ic_req = 0; im_addr = 0; dm_rd = 0; dm_wen = 0; dm_addr = 0;
    dm_wd = 0; dm_f3 = 0; bus_rdata = 0; bus_ready = 0;
    m_open = 0; m_resp = 0; m_owner_data = 0; m_last_data = 1;
    m_addr = PCR; m_wdata = 0; m_wen = 0; m_f3 = 0; m_rdata = 0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_addr_lit", bus_addr, PCR);
    chk("rst_req_lit", 32'(bus_req), 32'd0);
    chk("rst_f3_lit", 32'(bus_f3), 32'd0);
    rst = 0;
    cyc();

    // Fetch only, bus ready in the first BUSY cycle.
    ic_req = 1; im_addr = 32'h100;
    cyc();
    chk("fetch_req_lit", 32'(bus_req), 32'd1);
    chk("fetch_addr_lit", bus_addr, 32'h100);
    chk("fetch_f3_lit", 32'(bus_f3), 32'd2);
    bus_ready = 1; bus_rdata = 32'h0000_0013;
    cyc();
    chk("fetch_rdy_lit", 32'(ic_rdy), 32'd1);
    chk("fetch_instr_lit", im_instr, 32'h0000_0013);
    ic_req = 0; bus_ready = 0;
    cyc();
    chk("fetch_pulse_end_lit", 32'(ic_rdy), 32'd0);

    // Store with three BUSY cycles; inputs wander but bus fields must not.
    dm_wen = 1; dm_addr = 32'h2000; dm_wd = 32'hDEAD_BEEF; dm_f3 = 3'b010;
    cyc();
    dm_addr = 32'h5555_0000; dm_wd = 32'h1234_5678; dm_f3 = 3'b001;
    for (int k = 0; k < 3; k++) begin
      chk("st_req_lit", 32'(bus_req), 32'd1);
      chk("st_addr_lit", bus_addr, 32'h2000);
      chk("st_wdata_lit", bus_wdata, 32'hDEAD_BEEF);
      chk("st_wen_lit", 32'(bus_wen), 32'd1);
      if (k == 2) begin bus_ready = 1; bus_rdata = 32'hA5A5_0001; end
      cyc();
    end
    chk("st_rdy_lit", 32'(dm_rdy), 32'd1);
    chk("st_ic_quiet_lit", 32'(ic_rdy), 32'd0);
    dm_wen = 0; bus_ready = 0;
    cyc();

    // Simultaneous fetch 0x40 and load 0x3000.
    ic_req = 1; im_addr = 32'h40;
    dm_rd = 1; dm_addr = 32'h3000; dm_f3 = 3'b100;
`ifdef ARVI_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      do_txn(g, 32'h100 + 32'(k));
      chk("rr_grant_lit", g, (k % 2 == 0) ? 32'h40 : 32'h3000);
      if (k == 3) begin ic_req = 0; dm_rd = 0; end
      cyc();
    end
`else
    do_txn(g, 32'h0000_0111);
    chk("pri_first_lit", g, 32'h3000);
    chk("pri_first_rdy_lit", 32'(dm_rdy), 32'd1);
    dm_rd = 0;
    cyc();
    do_txn(g, 32'h0000_0222);
    chk("pri_second_lit", g, 32'h40);
    chk("pri_second_rdy_lit", 32'(ic_rdy), 32'd1);
    ic_req = 0;
    cyc();
`endif

    // Spurious bus ready in IDLE and in RESP.
    bus_ready = 1; bus_rdata = 32'hBAD0_0000;
    cyc();
    chk("idle_spur_req_lit", 32'(bus_req), 32'd0);
    chk("idle_spur_rdy_lit", 32'(ic_rdy | dm_rdy), 32'd0);
    bus_ready = 0;
    ic_req = 1; im_addr = 32'h400;
    cyc();
    bus_ready = 1; bus_rdata = 32'h0000_0777;
    cyc();
    ic_req = 0;
    cyc();
    chk("resp_spur_req_lit", 32'(bus_req), 32'd0);
    chk("resp_spur_rdy_lit", 32'(ic_rdy | dm_rdy), 32'd0);
    bus_ready = 0;
    cyc();

    // Reset while BUSY abandons the transaction.
    ic_req = 1; im_addr = 32'h500;
    cyc();
    rst = 1; ic_req = 0;
    cyc();
    chk("rst_busy_req_lit", 32'(bus_req), 32'd0);
    chk("rst_busy_addr_lit", bus_addr, PCR);
    rst = 0; bus_ready = 1;
    cyc();
    chk("rst_busy_norsp_lit", 32'(ic_rdy | dm_rdy), 32'd0);
    bus_ready = 0;
    cyc();

    // Fetch request kept high after its pulse starts a second fetch.
    ic_req = 1; im_addr = 32'h600;
    do_txn(g, 32'h0000_0666);
    chk("hold_rdy_lit", 32'(ic_rdy), 32'd1);
    cyc();
    chk("hold_gap_lit", 32'(bus_req), 32'd0);
    cyc();
    chk("hold_again_lit", 32'(bus_req), 32'd1);
    bus_ready = 1;
    cyc();
    ic_req = 0; bus_ready = 0;
    cyc();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (ic_rdy) begin
        if ($urandom_range(0, 3) != 0) ic_req = 0;
      end else if (!ic_req && $urandom_range(0, 2) == 0) begin
        ic_req = 1; im_addr = $urandom();
      end
      if (dm_rdy) begin
        if ($urandom_range(0, 3) != 0) begin dm_rd = 0; dm_wen = 0; end
      end else if (!(dm_rd | dm_wen) && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       begin dm_rd = 1; dm_wen = 0; end
          1:       begin dm_rd = 0; dm_wen = 1; end
          default: begin dm_rd = 1; dm_wen = 1; end
        endcase
        dm_addr = $urandom(); dm_wd = $urandom(); dm_f3 = 3'($urandom_range(0, 7));
      end
      bus_rdata = $urandom();
      if (bus_req) bus_ready = ($urandom_range(0, 2) == 0);
      else         bus_ready = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
